// File: rtl/sram_1rw_req_ctrl_if.sv
// Request/response stream bundle between a client and the 1RW SRAM request controller.
// The client drives requests and response-ready; the controller drives the rest.
interface sram_1rw_req_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_1rw_req_ctrl.sv
// Initiator for a single-port 1RW SRAM macro: turns a valid/ready request stream into macro
// pin activity and returns read data in order through a small credit-protected response FIFO.
module sram_1rw_req_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_1rw_req_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    logic              running;
    logic              inflight;
    logic              fire;
    logic              rd_fire;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W:0]    credit_used;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [RSP_DEPTH];

    // A read in flight already owns a FIFO slot, and a slot being popped this cycle is free again.
    assign credit_used   = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign bus.req_ready = running & (credit_used < DEPTH_C);

    assign fire    = bus.req_valid & bus.req_ready;
    assign rd_fire = fire & ~bus.req_we;

    assign sram_csb = ~fire;
    assign sram_web = ~(fire & bus.req_we);
    assign sram_a   = fire ? bus.req_addr : '0;
    assign sram_i   = (fire & bus.req_we) ? bus.req_wdata : '0;
    assign sram_oeb = ~inflight;

    assign empty         = (occ == '0);
    assign full          = (occ == FULL_C);
    assign push          = inflight;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign bus.rsp_valid = ~empty;
    assign bus.rsp_rdata = mem[rd_ptr];

    // running keeps req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running  <= 1'b0;
            inflight <= 1'b0;
        end else begin
            running  <= 1'b1;
            inflight <= rd_fire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= sram_o;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
        else $error("sram_1rw_req_ctrl: response FIFO push while full");

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Self-checking bench for sram_1rw_req_ctrl: behavioural 1RW macro, reference memory and
// an expected-response queue compared as responses are consumed.
module tb_sram_1rw_req_ctrl;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int RSP_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] sram_a;
    logic              sram_csb;
    logic              sram_web;
    logic              sram_oeb;
    logic [DATA_W-1:0] sram_i;
    wire  [DATA_W-1:0] sram_o;

    logic [DATA_W-1:0] macro_mem [64];
    logic [DATA_W-1:0] macro_dout;
    logic [DATA_W-1:0] model_mem [64];
    logic [DATA_W-1:0] exp_q [$];

    int total  = 0;
    int passed = 0;

    sram_1rw_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_1rw_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sram_a   (sram_a),
        .sram_csb (sram_csb),
        .sram_web (sram_web),
        .sram_oeb (sram_oeb),
        .sram_i   (sram_i),
        .sram_o   (sram_o)
    );

    always #5 clk = ~clk;

    // Macro model: synchronous access on CE=clk, output floats whenever OEB is high.
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) macro_mem[sram_a] <= sram_i;
            else           macro_dout        <= macro_mem[sram_a];
        end
    end
    assign sram_o = sram_oeb ? 'z : macro_dout;

    // One cycle: drive at negedge, observe just after; accepted requests update the model/queue.
    task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic rr,
                        output logic fired, output logic popped, output logic [DATA_W-1:0] rdata);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.rsp_ready = rr;
        #1;
        fired  = v & bus.req_ready;
        popped = bus.rsp_valid & rr;
        rdata  = bus.rsp_rdata;
        if (fired) begin
            if (we) model_mem[addr] = wd;
            else    exp_q.push_back(model_mem[addr]);
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'h2A;
        bus.req_wdata = 32'h1234_5678;
        bus.rsp_ready = 1'b1;
        #12;
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            $display("[TB] FAIL reset_stream: got %h expected %h",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_rdata}, {1'b0, 1'b0, 32'h0});
        end else passed++;
        total++;
        if ({sram_csb, sram_web, sram_oeb, sram_a, sram_i} !== {1'b1, 1'b1, 1'b1, 6'h0, 32'h0}) begin
            $display("[TB] FAIL reset_macro: got %h expected %h",
                     {sram_csb, sram_web, sram_oeb, sram_a, sram_i}, {1'b1, 1'b1, 1'b1, 6'h0, 32'h0});
        end else passed++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b0) begin
            $display("[TB] FAIL ready_before_edge: got %b expected 0", bus.req_ready);
        end else passed++;
        @(negedge clk);
        #1;
        total++;
        if (bus.req_ready !== 1'b1) begin
            $display("[TB] FAIL ready_after_release: got %b expected 1", bus.req_ready);
        end else passed++;
    endtask

    task automatic test_write_read;
        logic f, p;
        logic [DATA_W-1:0] d, e;
        step(1'b1, 1'b1, 6'h05, 32'hDEAD_BEEF, 1'b1, f, p, d);
        total++;
        if ({f, sram_csb, sram_web, sram_a, sram_i} !== {1'b1, 1'b0, 1'b0, 6'h05, 32'hDEAD_BEEF}) begin
            $display("[TB] FAIL write_pins: got %h expected %h",
                     {f, sram_csb, sram_web, sram_a, sram_i}, {1'b1, 1'b0, 1'b0, 6'h05, 32'hDEAD_BEEF});
        end else passed++;
        step(1'b1, 1'b0, 6'h05, 32'h0, 1'b1, f, p, d);
        total++;
        if ({f, sram_csb, sram_web, sram_oeb, sram_a, sram_i} !== {1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 32'h0}) begin
            $display("[TB] FAIL read_pins: got %h expected %h",
                     {f, sram_csb, sram_web, sram_oeb, sram_a, sram_i}, {1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 32'h0});
        end else passed++;
        step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, f, p, d);
        total++;
        if ({p, sram_oeb} !== 2'b00) begin
            $display("[TB] FAIL read_latency_1: got valid/oeb %b expected 00", {p, sram_oeb});
        end else passed++;
        step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, f, p, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        total++;
        if ({p, sram_oeb, d} !== {1'b1, 1'b1, 32'hDEAD_BEEF} || e !== 32'hDEAD_BEEF) begin
            $display("[TB] FAIL read_after_write: got valid/oeb/data %h expected %h",
                     {p, sram_oeb, d}, {1'b1, 1'b1, 32'hDEAD_BEEF});
        end else passed++;
    endtask

    task automatic test_back_to_back;
        logic f, p;
        logic [DATA_W-1:0] d, e;
        int n_wr = 0, n_rd = 0, pops = 0, first = -1, last = -1, cyc = 0;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 1'b1, ADDR_W'(k), DATA_W'(k * 3), 1'b1, f, p, d);
            if (f) n_wr++;
        end
        total++;
        if (n_wr !== 64) $display("[TB] FAIL stream_writes: got %0d expected 64", n_wr);
        else passed++;
        while (cyc < 72) begin
            if (cyc < 64) step(1'b1, 1'b0, ADDR_W'(cyc), 32'h0, 1'b1, f, p, d);
            else          step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, f, p, d);
            if (cyc < 64 && f) n_rd++;
            if (p) begin
                if (first < 0) first = cyc;
                last = cyc;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                total++;
                if (d !== e || e !== DATA_W'(pops * 3)) begin
                    $display("[TB] FAIL stream_data[%0d]: got %h expected %h", pops, d, pops * 3);
                end else passed++;
                pops++;
            end
            cyc++;
        end
        total++;
        if (n_rd !== 64) $display("[TB] FAIL stream_reads: got %0d expected 64", n_rd);
        else passed++;
        total++;
        if ({pops, first, last} !== {32'd64, 32'd2, 32'd65}) begin
            $display("[TB] FAIL stream_timing: got pops=%0d first=%0d last=%0d expected 64 2 65",
                     pops, first, last);
        end else passed++;
    endtask

    task automatic test_backpressure;
        logic f, p;
        logic [DATA_W-1:0] d, e, hold;
        int issued = 0, pops = 0, cyc = 0;
        bit have_hold = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b0, ADDR_W'(10 + issued), 32'h0, 1'b0, f, p, d);
            if (f) issued++;
            if (bus.rsp_valid) begin
                if (!have_hold) begin
                    hold      = d;
                    have_hold = 1;
                    total++;
                    if (exp_q.size() == 0 || d !== exp_q[0]) begin
                        $display("[TB] FAIL stall_head: got %h expected %h", d, DATA_W'(30));
                    end else passed++;
                end else begin
                    total++;
                    if (d !== hold) $display("[TB] FAIL stall_stable: got %h expected %h", d, hold);
                    else passed++;
                end
            end
        end
        total++;
        if ({issued, 31'd0, bus.req_ready} !== {RSP_DEPTH, 32'd0}) begin
            $display("[TB] FAIL stall_credit: got issued=%0d ready=%b expected %0d 0",
                     issued, bus.req_ready, RSP_DEPTH);
        end else passed++;
        step(1'b1, 1'b1, 6'h3F, 32'hBAD0_BAD0, 1'b0, f, p, d);
        total++;
        if (f !== 1'b0) $display("[TB] FAIL stall_write_blocked: got fired=%b expected 0", f);
        else passed++;
        while ((issued < 4 || exp_q.size() > 0) && cyc < 20) begin
            step(issued < 4, 1'b0, ADDR_W'(10 + issued), 32'h0, 1'b1, f, p, d);
            if (f) issued++;
            if (p) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                total++;
                if (d !== e || e !== DATA_W'((10 + pops) * 3)) begin
                    $display("[TB] FAIL bp_data[%0d]: got %h expected %h", pops, d, (10 + pops) * 3);
                end else passed++;
                pops++;
            end
            cyc++;
        end
        total++;
        if ({issued, pops} !== {32'd4, 32'd4}) begin
            $display("[TB] FAIL bp_count: got issued=%0d pops=%0d expected 4 4", issued, pops);
        end else passed++;
    endtask

    task automatic test_random;
        logic f, p, v, we, rr;
        logic [DATA_W-1:0] d, e;
        int n = 0, cyc = 0, drain = 0;
        while (n < 10000 && cyc < 60000) begin
            v  = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            rr = $urandom_range(0, 1) == 1;
            step(v, we, ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom), rr, f, p, d);
            if (f) n++;
            if (p) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                total++;
                if (d !== e) $display("[TB] FAIL random_data: got %h expected %h", d, e);
                else passed++;
            end
            cyc++;
        end
        while (exp_q.size() > 0 && drain < 20) begin
            step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, f, p, d);
            if (p) begin
                e = exp_q.pop_front();
                total++;
                if (d !== e) $display("[TB] FAIL random_drain: got %h expected %h", d, e);
                else passed++;
            end
            drain++;
        end
        total++;
        if ({n, exp_q.size()} !== {32'd10000, 32'd0}) begin
            $display("[TB] FAIL random_done: got requests=%0d left=%0d expected 10000 0", n, exp_q.size());
        end else passed++;
    endtask

    task automatic reset_pulse_and_watch(input string name);
        logic f, p;
        logic [DATA_W-1:0] d;
        int seen = 0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rsp_valid, bus.req_ready, sram_oeb} !== 3'b001) begin
            $display("[TB] FAIL %s_assert: got valid/ready/oeb %b expected 001", name,
                     {bus.rsp_valid, bus.req_ready, sram_oeb});
        end else passed++;
        exp_q.delete();
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, f, p, d);
            if (bus.rsp_valid) seen++;
        end
        total++;
        if (seen !== 0) $display("[TB] FAIL %s_stale: got %0d responses expected 0", name, seen);
        else passed++;
    endtask

    task automatic test_reset_midop;
        logic f, p, f2;
        logic [DATA_W-1:0] d, e;
        int pops = 0;
        step(1'b1, 1'b0, 6'd1, 32'h0, 1'b0, f, p, d);
        step(1'b1, 1'b0, 6'd2, 32'h0, 1'b0, f2, p, d);
        step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, f, p, d);
        total++;
        if ({f2, bus.rsp_valid, sram_oeb} !== 3'b110) begin
            $display("[TB] FAIL midop_setup: got fired/valid/oeb %b expected 110", {f2, bus.rsp_valid, sram_oeb});
        end else passed++;
        reset_pulse_and_watch("rst_inflight");
        step(1'b1, 1'b0, 6'd3, 32'h0, 1'b0, f, p, d);
        step(1'b1, 1'b0, 6'd4, 32'h0, 1'b0, f, p, d);
        step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, f, p, d);
        step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, f, p, d);
        total++;
        if ({bus.rsp_valid, bus.req_ready, exp_q.size()} !== {1'b1, 1'b0, 32'd2}) begin
            $display("[TB] FAIL full_setup: got valid=%b ready=%b queued=%0d expected 1 0 2",
                     bus.rsp_valid, bus.req_ready, exp_q.size());
        end else passed++;
        reset_pulse_and_watch("rst_full");
        step(1'b1, 1'b0, 6'd7, 32'h0, 1'b1, f, p, d);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, f, p, d);
            if (p) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                total++;
                if (d !== e || e !== model_mem[7]) $display("[TB] FAIL post_reset_read: got %h expected %h", d, model_mem[7]);
                else passed++;
                pops++;
            end
        end
        total++;
        if (pops !== 1) $display("[TB] FAIL post_reset_count: got %0d expected 1", pops);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            macro_mem[i] = '0;
            model_mem[i] = '0;
        end
        macro_dout = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
